// File: rtl/actor_move_sequencer.sv
// actor_move_sequencer: per-frame movement scheduler that walks each actor through a wall probe and commits or blocks its step.
// Latency: 2 cycles per actor (4 when a turn attempt hits a wall); done follows the last actor's commit edge.
// Backpressure: none; frame ticks seen while busy or during the done cycle are dropped and set sticky overrun.
module actor_move_sequencer #(
  parameter int NUM_ACTORS = 5,
  parameter int COORD_W    = 10,
  parameter int TILE_SHIFT = 3,
  parameter int ACTOR_SIZE = 8,
  parameter int MAZE_COLS  = 28,
  parameter int MAZE_ROWS  = 31,
  parameter int MAZE_AW    = 10,
  parameter logic [NUM_ACTORS*COORD_W-1:0] INIT_X   = '0,
  parameter logic [NUM_ACTORS*COORD_W-1:0] INIT_Y   = '0,
  parameter logic [NUM_ACTORS*2-1:0]       INIT_DIR = '0
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic                            vs,
  input  logic [NUM_ACTORS-1:0]           req_valid,
  input  logic [2*NUM_ACTORS-1:0]         req_dir,
  output logic                            maze_rd,
  output logic [MAZE_AW-1:0]              maze_addr,
  input  logic                            maze_wall,
  output logic [COORD_W*NUM_ACTORS-1:0]   pos_x,
  output logic [COORD_W*NUM_ACTORS-1:0]   pos_y,
  output logic [2*NUM_ACTORS-1:0]         cur_dir,
  output logic                            busy,
  output logic                            done,
  output logic                            overrun
);

  localparam int IDX_W = (NUM_ACTORS > 1) ? $clog2(NUM_ACTORS) : 1;
  localparam int PW    = COORD_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ACTORS - 1);
  localparam logic [31:0] LP_COLS = 32'(MAZE_COLS);
  localparam logic [31:0] LP_ROWS = 32'(MAZE_ROWS);

  localparam logic [1:0] DIR_R = 2'b00;
  localparam logic [1:0] DIR_L = 2'b01;
  localparam logic [1:0] DIR_U = 2'b10;

  // The "next actor" decision is folded into the CHK states, so it has no state of its own.
  typedef enum logic [2:0] {
    S_IDLE, S_PROBE_REQ, S_CHK_REQ, S_PROBE_CUR, S_CHK_CUR
  } state_t;

  state_t r_state, w_state_nxt;

  logic                 r_vs_d;
  logic [IDX_W-1:0]     r_idx;
  logic [COORD_W-1:0]   r_pos_x [NUM_ACTORS];
  logic [COORD_W-1:0]   r_pos_y [NUM_ACTORS];
  logic [1:0]           r_dir   [NUM_ACTORS];
  logic [1:0]           r_try_dir;
  logic                 r_oob;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_overrun;

  logic                 w_tick;
  logic                 w_start;
  logic                 w_last;
  logic [COORD_W-1:0]   w_x;
  logic [COORD_W-1:0]   w_y;
  logic [1:0]           w_dir;
  logic                 w_req_vld;
  logic [1:0]           w_req_dir;
  logic                 w_turn_ok;
  logic                 w_attempt;
  logic [1:0]           w_probe_dir;
  logic [PW-1:0]        w_px;
  logic [PW-1:0]        w_py;
  logic [PW-1:0]        w_col;
  logic [PW-1:0]        w_row;
  logic                 w_oob;
  logic [MAZE_AW-1:0]   w_addr;
  logic                 w_blocked;
  logic                 w_probe;
  logic                 w_commit;

  // vsync is active low: a frame tick is a registered-high, now-low sample.
  assign w_tick  = r_vs_d & ~vs;
  assign w_start = w_tick && (r_state == S_IDLE) && !r_done;
  assign w_last  = (r_idx == LAST_IDX);

  assign w_x       = r_pos_x[r_idx];
  assign w_y       = r_pos_y[r_idx];
  assign w_dir     = r_dir[r_idx];
  assign w_req_vld = req_valid[r_idx];
  assign w_req_dir = req_dir[{r_idx, 1'b0} +: 2];

  // Same-axis reversals are always allowed; a perpendicular turn needs the actor tile-aligned on the other axis.
  assign w_turn_ok = (w_req_dir[1] == w_dir[1]) ||
                     (w_req_dir[1] ? (w_x[TILE_SHIFT-1:0] == '0) : (w_y[TILE_SHIFT-1:0] == '0));
  assign w_attempt   = w_req_vld && (w_req_dir != w_dir) && w_turn_ok;
  assign w_probe_dir = ((r_state == S_PROBE_REQ) && w_attempt) ? w_req_dir : w_dir;

  // Leading-edge probe point one pixel ahead of the sprite in the probed direction.
  always_comb begin
    w_px = {1'b0, w_x};
    w_py = {1'b0, w_y};
    case (w_probe_dir)
      DIR_R:   w_px = {1'b0, w_x} + PW'(ACTOR_SIZE);
      DIR_L:   w_px = {1'b0, w_x} - PW'(1);
      DIR_U:   w_py = {1'b0, w_y} - PW'(1);
      default: w_py = {1'b0, w_y} + PW'(ACTOR_SIZE);
    endcase
  end

  assign w_col  = w_px >> TILE_SHIFT;
  assign w_row  = w_py >> TILE_SHIFT;
  assign w_oob  = ((w_probe_dir == DIR_L) && (w_x == '0)) ||
                  ((w_probe_dir == DIR_U) && (w_y == '0)) ||
                  (32'(w_col) >= LP_COLS) || (32'(w_row) >= LP_ROWS);
  assign w_addr = MAZE_AW'(32'(w_row) * LP_COLS + 32'(w_col));

  // Off-maze probes never touch the RAM and always read as a wall.
  assign w_blocked = r_oob | maze_wall;

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state: one or two probes per actor, then on to the next actor or back to idle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (w_start) w_state_nxt = S_PROBE_REQ;
      S_PROBE_REQ: w_state_nxt = w_attempt ? S_CHK_REQ : S_CHK_CUR;
      S_CHK_REQ: begin
        if (w_blocked)   w_state_nxt = S_PROBE_CUR;
        else if (w_last) w_state_nxt = S_IDLE;
        else             w_state_nxt = S_PROBE_REQ;
      end
      S_PROBE_CUR: w_state_nxt = S_CHK_CUR;
      S_CHK_CUR:   w_state_nxt = w_last ? S_IDLE : S_PROBE_REQ;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs: RAM strobe during probe cycles, commit strobe when an actor finishes.
  always_comb begin
    w_probe  = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      S_PROBE_REQ, S_PROBE_CUR: w_probe  = 1'b1;
      S_CHK_REQ:                w_commit = !w_blocked;
      S_CHK_CUR:                w_commit = 1'b1;
      default: ;
    endcase
    maze_rd   = w_probe && !w_oob && !Reset;
    maze_addr = maze_rd ? w_addr : '0;
  end

  // Actor state, sequencing bookkeeping and status flags.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_vs_d    <= 1'b0;
      r_idx     <= '0;
      r_try_dir <= 2'b00;
      r_oob     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
      for (int i = 0; i < NUM_ACTORS; i++) begin
        r_pos_x[i] <= INIT_X[i*COORD_W +: COORD_W];
        r_pos_y[i] <= INIT_Y[i*COORD_W +: COORD_W];
        r_dir[i]   <= INIT_DIR[i*2 +: 2];
      end
    end else begin
      r_vs_d <= vs;
      r_done <= 1'b0;
      if (w_tick && (r_busy || r_done)) r_overrun <= 1'b1;
      if (w_start) begin
        r_idx  <= '0;
        r_busy <= 1'b1;
      end
      if (w_probe) begin
        r_try_dir <= w_probe_dir;
        r_oob     <= w_oob;
      end
      if (w_commit) begin
        if (!w_blocked) begin
          case (r_try_dir)
            DIR_R:   r_pos_x[r_idx] <= w_x + COORD_W'(1);
            DIR_L:   r_pos_x[r_idx] <= w_x - COORD_W'(1);
            DIR_U:   r_pos_y[r_idx] <= w_y - COORD_W'(1);
            default: r_pos_y[r_idx] <= w_y + COORD_W'(1);
          endcase
        end
        r_dir[r_idx] <= r_try_dir;
        if (w_last) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end else begin
          r_idx <= r_idx + IDX_W'(1);
        end
      end
    end
  end

  // Flatten per-actor registers onto the packed output buses.
  always_comb begin
    pos_x   = '0;
    pos_y   = '0;
    cur_dir = '0;
    for (int i = 0; i < NUM_ACTORS; i++) begin
      pos_x[i*COORD_W +: COORD_W] = r_pos_x[i];
      pos_y[i*COORD_W +: COORD_W] = r_pos_y[i];
      cur_dir[i*2 +: 2]           = r_dir[i];
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_actor_move_sequencer.sv
// tb_actor_move_sequencer: frame-level scoreboard for actor_move_sequencer.
// Latency: expected probe addresses and end-of-frame positions are queued when a frame is launched.
// Backpressure: a behavioural wall RAM answers maze_rd one cycle later.
module tb_actor_move_sequencer;
  localparam int NA = 5;
  localparam int CW = 10;
  localparam logic [NA*CW-1:0] P_INIT_X   = {10'd216, 10'd0,  10'd100, 10'd40, 10'd8};
  localparam logic [NA*CW-1:0] P_INIT_Y   = {10'd8,   10'd40, 10'd200, 10'd16, 10'd8};
  localparam logic [NA*2-1:0]  P_INIT_DIR = {2'b00, 2'b01, 2'b01, 2'b11, 2'b00};

  int         init_x [NA] = '{8, 40, 100, 0, 216};
  int         init_y [NA] = '{8, 16, 200, 40, 8};
  logic [1:0] init_d [NA] = '{2'b00, 2'b11, 2'b01, 2'b01, 2'b00};

  logic              clk = 1'b0;
  logic              Reset;
  logic              vs;
  logic [NA-1:0]     req_valid;
  logic [2*NA-1:0]   req_dir;
  logic              maze_rd;
  logic [9:0]        maze_addr;
  logic              maze_wall = 1'b0;
  logic [CW*NA-1:0]  pos_x;
  logic [CW*NA-1:0]  pos_y;
  logic [2*NA-1:0]   cur_dir;
  logic              busy;
  logic              done;
  logic              overrun;

  typedef struct { int x; int y; int d; } exp_t;

  bit         wall_mem [1024];
  int         mx [NA];
  int         my [NA];
  logic [1:0] md [NA];
  int         exp_addr_q [$];
  exp_t       exp_pos_q [$];
  int         exp_lat;
  int         exp_rd_cnt;
  int         frame_rd_cnt;
  int         first_addr;
  int         last_lat;
  logic       exp_ovr;
  int         n_checks = 0;
  int         n_errors = 0;

  actor_move_sequencer #(
    .NUM_ACTORS(NA), .COORD_W(CW), .TILE_SHIFT(3), .ACTOR_SIZE(8),
    .MAZE_COLS(28), .MAZE_ROWS(31), .MAZE_AW(10),
    .INIT_X(P_INIT_X), .INIT_Y(P_INIT_Y), .INIT_DIR(P_INIT_DIR)
  ) dut (
    .Clk(clk), .Reset(Reset), .vs(vs), .req_valid(req_valid), .req_dir(req_dir),
    .maze_rd(maze_rd), .maze_addr(maze_addr), .maze_wall(maze_wall),
    .pos_x(pos_x), .pos_y(pos_y), .cur_dir(cur_dir),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Wall RAM with one cycle of read latency.
  always @(posedge clk) if (maze_rd) maze_wall <= wall_mem[maze_addr];

  // Every RAM read must match the next probe the model predicted.
  always @(negedge clk) begin
    if (maze_rd === 1'b1) begin
      if (frame_rd_cnt == 0) first_addr = int'(maze_addr);
      frame_rd_cnt++;
      if (exp_addr_q.size() == 0) check_eq("rd_unexpected", maze_addr, 0);
      else check_eq("rd_addr", maze_addr, exp_addr_q.pop_front());
    end
  end

  // Probe of the tile ahead of (x,y) in direction d; returns 1 when blocked.
  function automatic bit probe(input int x, input int y, input logic [1:0] d,
                               output int addr, output bit oob);
    int px, py;
    px = x;
    py = y;
    case (d)
      2'b00:   px = x + 8;
      2'b01:   px = x - 1;
      2'b10:   py = y - 1;
      default: py = y + 8;
    endcase
    oob  = (d == 2'b01 && x == 0) || (d == 2'b10 && y == 0) || (px / 8 >= 28) || (py / 8 >= 31);
    addr = ((py / 8) * 28 + px / 8) % 1024;
    if (oob) return 1'b1;
    return wall_mem[addr];
  endfunction

  function automatic void move(input int i, input logic [1:0] d);
    case (d)
      2'b00:   mx[i] = mx[i] + 1;
      2'b01:   mx[i] = mx[i] - 1;
      2'b10:   my[i] = my[i] - 1;
      default: my[i] = my[i] + 1;
    endcase
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NA; i++) begin
      mx[i] = init_x[i];
      my[i] = init_y[i];
      md[i] = init_d[i];
    end
    exp_addr_q.delete();
    exp_pos_q.delete();
  endfunction

  // Reference frame: per actor, optional turn probe, then fall back to the current heading.
  function automatic void model_frame(input logic [NA-1:0] rv, input logic [2*NA-1:0] rd);
    logic [1:0] want;
    bit try_it, blk, o, moved;
    int a;
    exp_t e;
    exp_lat    = 0;
    exp_rd_cnt = 0;
    for (int i = 0; i < NA; i++) begin
      want   = rd[2*i +: 2];
      moved  = 1'b0;
      try_it = rv[i] && (want != md[i]) &&
               ((want[1] == md[i][1]) || (want[1] ? (mx[i] % 8 == 0) : (my[i] % 8 == 0)));
      if (try_it) begin
        blk = probe(mx[i], my[i], want, a, o);
        if (!o) begin exp_addr_q.push_back(a); exp_rd_cnt++; end
        exp_lat += 2;
        if (!blk) begin move(i, want); md[i] = want; moved = 1'b1; end
      end
      if (!moved) begin
        blk = probe(mx[i], my[i], md[i], a, o);
        if (!o) begin exp_addr_q.push_back(a); exp_rd_cnt++; end
        exp_lat += 2;
        if (!blk) move(i, md[i]);
      end
      e.x = mx[i];
      e.y = my[i];
      e.d = int'(md[i]);
      exp_pos_q.push_back(e);
    end
  endfunction

  // mode 0: plain frame; 1: extra tick mid-sequence; 2: extra tick in the done cycle.
  task automatic run_frame(input logic [NA-1:0] rv, input logic [2*NA-1:0] rd, input int mode);
    int n;
    exp_t e;
    @(negedge clk);
    req_valid    = rv;
    req_dir      = rd;
    frame_rd_cnt = 0;
    if (mode != 0) exp_ovr = 1'b1;
    model_frame(rv, rd);
    vs = 1'b0;
    @(negedge clk);
    vs = 1'b1;
    check_eq("busy_start", busy, 1);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
      if (mode == 1 && n == 3) vs = 1'b0;
      if (mode == 1 && n == 4) vs = 1'b1;
    end
    last_lat = n;
    check_eq("done_latency", n, exp_lat);
    check_eq("rd_count", frame_rd_cnt, exp_rd_cnt);
    for (int i = 0; i < NA; i++) begin
      e = exp_pos_q.pop_front();
      check_eq($sformatf("pos_x%0d", i), pos_x[i*CW +: CW], e.x);
      check_eq($sformatf("pos_y%0d", i), pos_y[i*CW +: CW], e.y);
      check_eq($sformatf("dir%0d", i), cur_dir[i*2 +: 2], e.d);
    end
    check_eq("busy_end", busy, 0);
    if (mode == 2) vs = 1'b0;
    @(negedge clk);
    vs = 1'b1;
    check_eq("done_pulse", done, 0);
    check_eq("no_restart", busy, 0);
    check_eq("overrun", overrun, exp_ovr);
    req_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; vs = 1'b1; req_valid = '0; req_dir = '0; exp_ovr = 1'b0;
    frame_rd_cnt = 0; first_addr = -1; last_lat = 0;
    repeat (3) @(negedge clk);
    Reset = 1'b0;
    model_reset();
    @(negedge clk);
    check_eq("rst_x0", pos_x[9:0], 8);
    check_eq("rst_y0", pos_y[9:0], 8);
    check_eq("rst_pos_x", pos_x, P_INIT_X);
    check_eq("rst_pos_y", pos_y, P_INIT_Y);
    check_eq("rst_dir", cur_dir, P_INIT_DIR);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rd", maze_rd, 0);
    check_eq("rst_addr", maze_addr, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_overrun", overrun, 0);

    // Pacman blocked ahead; ghost 1 tries a right turn into a wall and falls back to down.
    wall_mem[30] = 1'b1;
    wall_mem[62] = 1'b1;
    run_frame(5'b00010, 10'b0000000000, 0);
    check_eq("blocked_x0", pos_x[9:0], 8);
    check_eq("blocked_dir0", cur_dir[1:0], 0);
    check_eq("fallback_lat", last_lat, 12);

    // Open path, no turn attempts.
    wall_mem[30] = 1'b0;
    run_frame('0, '0, 0);
    check_eq("open_x0", pos_x[9:0], 9);
    check_eq("open_addr0", first_addr, 30);
    check_eq("open_lat", last_lat, 10);

    // Unaligned up request is ignored.
    run_frame(5'b00001, 10'b0000000010, 0);
    check_eq("unaligned_x0", pos_x[9:0], 10);
    check_eq("unaligned_dir0", cur_dir[1:0], 0);
    run_frame(5'b00001, 10'b0000000001, 0);
    run_frame('0, '0, 0);
    // Aligned up turn at (8,8) probes tile 1.
    run_frame(5'b00001, 10'b0000000010, 0);
    check_eq("turn_y0", pos_y[9:0], 7);
    check_eq("turn_dir0", cur_dir[1:0], 2);
    check_eq("turn_addr0", first_addr, 1);
    run_frame(5'b00001, 10'b0000000011, 0);
    run_frame(5'b00001, 10'b0000000001, 0);
    repeat (7) run_frame('0, '0, 0);
    check_eq("edge_x0", pos_x[9:0], 0);
    // Left edge of the maze: no read, no movement.
    run_frame('0, '0, 0);
    check_eq("oob_x0", pos_x[9:0], 0);
    check_eq("oob_y0", pos_y[9:0], 8);

    // Random requests and walls.
    for (int f = 0; f < 12; f++) begin
      repeat (15) wall_mem[$urandom_range(0, 1023)] = 1'($urandom_range(0, 1));
      run_frame(NA'($urandom_range(0, 31)), (2*NA)'($urandom_range(0, 1023)), 0);
    end

    // Tick while busy: ignored, overrun set and sticky.
    run_frame(5'b00100, 10'b0000100000, 1);
    run_frame('0, '0, 0);

    // Reset in the middle of a sequence.
    @(negedge clk);
    frame_rd_cnt = 0;
    model_frame('0, '0);
    vs = 1'b0;
    @(negedge clk);
    vs = 1'b1;
    check_eq("mid_busy", busy, 1);
    repeat (3) @(negedge clk);
    Reset = 1'b1;
    model_reset();
    exp_ovr = 1'b0;
    @(negedge clk);
    check_eq("mrst_pos_x", pos_x, P_INIT_X);
    check_eq("mrst_pos_y", pos_y, P_INIT_Y);
    check_eq("mrst_dir", cur_dir, P_INIT_DIR);
    check_eq("mrst_busy", busy, 0);
    check_eq("mrst_rd", maze_rd, 0);
    check_eq("mrst_overrun", overrun, 0);
    // vs held low across reset release must not count as a tick.
    vs = 1'b0;
    @(negedge clk);
    Reset = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("no_tick_after_rst", busy, 0);
    vs = 1'b1;
    run_frame('0, '0, 0);
    // Tick landing in the done cycle counts as overrun.
    run_frame('0, '0, 2);

    check_eq("addr_q_empty", exp_addr_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
